gpr_file_sb: RTL

//  Parametrised multi-port integer register file with a per-register scoreboard, for the next-gen pipelined core.

---
 rtl/rf_pkg.sv | 38 +++
 rtl/gpr_file_sb_scoreboard.sv | 62 ++++++
 rtl/gpr_file_sb.sv | 87 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the integer register file.
// Provides address/data types and the lane-priority write-hit lookup.
package rf_pkg;

    localparam int RF_XLEN = 64;
    localparam int RF_NREG = 32;
    localparam int RF_AW   = $clog2(RF_NREG);
    // Widest write-port count the hit lookup supports.
    localparam int MAXWR   = 4;
    localparam int LW      = $clog2(MAXWR);

    typedef logic [RF_AW-1:0]   reg_addr_t;
    typedef logic [RF_XLEN-1:0] xlen_t;

    typedef struct packed {
        logic          hit;
        logic [LW-1:0] lane;
    } wr_hit_t;

    // Does any enabled lane write addr? Later lanes overwrite
    // earlier matches, so the highest lane index wins.
    function automatic wr_hit_t wr_hit(
        input reg_addr_t              addr,
        input logic [MAXWR-1:0]       en,
        input logic [MAXWR*RF_AW-1:0] addrs
    );
        wr_hit_t r;
        r = '0;
        for (int i = 0; i < MAXWR; i++) begin
            if (en[i] && addrs[i*RF_AW +: RF_AW] == addr) begin
                r.hit  = 1'b1;
                r.lane = LW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// Per-register busy scoreboard: alloc/clear/flush and read-port ready.
// Ports: clock, reset (async low), alloc_en/addr, flush, padded write
// lanes, rd_addr in; busy_vec and rd_ready out.
module gpr_file_sb_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int NRD  = 2,
    parameter int AW   = RF_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    input  logic [MAXWR-1:0]  wr_en,
    input  logic [MAXWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NREG-1:0]   busy_vec,
    output logic [NRD-1:0]    rd_ready
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] clr;

    for (genvar r = 0; r < NREG; r++) begin : g_clr
        wr_hit_t h;
        assign h      = wr_hit(AW'(r), wr_en, wr_addr);
        assign clr[r] = h.hit;
    end

    // flush > alloc > writeback clear > hold
    always_comb begin
        busy_nxt = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (flush)
                busy_nxt[r] = 1'b0;
            else if (alloc_en && alloc_addr == AW'(r))
                busy_nxt[r] = 1'b1;
            else if (clr[r])
                busy_nxt[r] = 1'b0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rdy
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
        assign rd_ready[i] = (a == '0) | ~busy_q[a] | clr[a];
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port integer register file with write bypass and scoreboard.
// Ports: clock, reset (async low), rd_addr/rd_data/rd_ready, wr_* lanes,
// alloc_en/alloc_addr, flush, busy_vec. NREG must match rf_pkg.
module gpr_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRD*RF_AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_ready,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*RF_AW-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_en,
    input  logic [RF_AW-1:0]     alloc_addr,
    input  logic                 flush,
    output logic [NREG-1:0]      busy_vec
);

    localparam int AW = RF_AW;

    logic [XLEN-1:0] regs [NREG];

    // Lanes padded to the lookup width; unused lanes stay disabled.
    logic [MAXWR-1:0]      en_pad;
    logic [MAXWR*AW-1:0]   addr_pad;
    logic [MAXWR*XLEN-1:0] data_pad;

    always_comb begin
        en_pad   = '0;
        addr_pad = '0;
        data_pad = '0;
        en_pad[NWR-1:0]        = wr_en;
        addr_pad[NWR*AW-1:0]   = wr_addr;
        data_pad[NWR*XLEN-1:0] = wr_data;
    end

    wr_hit_t whit [NREG];

    for (genvar r = 0; r < NREG; r++) begin : g_whit
        assign whit[r] = wr_hit(AW'(r), en_pad, addr_pad);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++)
                if (whit[r].hit)
                    regs[r] <= data_pad[whit[r].lane*XLEN +: XLEN];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] =
            (a == '0)     ? '0 :
            whit[a].hit   ? data_pad[whit[a].lane*XLEN +: XLEN] :
                            regs[a];
    end

    gpr_file_sb_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clock      (clock),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .wr_en      (en_pad),
        .wr_addr    (addr_pad),
        .rd_addr    (rd_addr),
        .busy_vec   (busy_vec),
        .rd_ready   (rd_ready)
    );

endmodule
